// File: rtl/latch_write_ctrl.sv
// Write controller for a level-sensitive D-latch array: accepts a word over
// valid/ready and drives D/en with a fixed setup -> pulse -> hold sequence.
module latch_write_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 1,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] D,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic [7:0]       wr_count
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Async reset clears en immediately so an interrupted pulse never lingers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            D        <= '0;
            en       <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_count <= 8'd0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= SETUP;
                        D        <= in_data;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= CNT_W'(SETUP_CYC - 1);
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= PULSE;
                        en    <= 1'b1;
                        cnt   <= CNT_W'(PULSE_CYC - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state <= HOLD;
                        en    <= 1'b0;
                        cnt   <= CNT_W'(HOLD_CYC - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    // D is left untouched here so the latches see it stable after en falls.
                    if (cnt == '0) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        wr_count <= wr_count + 8'd1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    en       <= 1'b0;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
